dual_key_encoder_74x148: RTL
============================

DUAL_KEY_ENCODER_74X148 -- requirements
Module: dual_key_encoder_74x148

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 4, the number of consecutive matching samples needed to accept a code (legal range 2..15).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_L  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports E1_L, E2_L  input  1 each  active-low channel enables.
REQ-005 SHALL have ports I1_L, I2_L  input  4 each  active-low request lines; bit 3 has the highest priority.
REQ-006 SHALL have ports ACK1, ACK2  input  1 each  consumer acknowledge, active-high.
REQ-007 SHALL have ports A1, A2  output  2 each  registered binary code of the accepted request.
REQ-008 SHALL have ports VALID1, VALID2  output  1 each  code-pending flag, active-high.
REQ-009 SHALL have ports GS1_L, GS2_L  output  1 each  registered group select, low when any enabled request is active.

Function
REQ-010 SHALL implement two identical, fully independent channels; channel n uses only En_L, In_L, ACKn, An, VALIDn and GSn_L.
REQ-011 SHALL register In_L into IREG every edge; all decisions below use IREG only, never raw In_L.
REQ-012 SHALL define the priority code of IREG as the index of the highest-numbered low bit (for example 4'b1010 gives code 2); "active" SHALL mean any IREG bit is low.
REQ-013 SHALL register GSn_L as NOT(active AND En_L low), with IREG timing.
REQ-014 SHALL run a 4-state FSM per channel: IDLE, DEBOUNCE, PRESENT, RELEASE.
REQ-015 In IDLE, when active, the FSM SHALL latch the priority code as CAND, set CNT=1 and go to DEBOUNCE; otherwise it SHALL stay in IDLE.
REQ-016 In DEBOUNCE with active and code==CAND:
- if CNT==DB_CYCLES-1, load An<=CAND, set VALIDn<=1 and go to PRESENT;
- otherwise CNT++.
REQ-017 In DEBOUNCE with active and code!=CAND, the FSM SHALL set CAND<=code and CNT=1, staying in DEBOUNCE.
REQ-018 In DEBOUNCE with not active, the FSM SHALL return to IDLE with CNT=0.
REQ-019 Latency: with IREG first capturing a stable code at edge 0, VALIDn and An SHALL update at edge DB_CYCLES.
REQ-020 In PRESENT, VALIDn SHALL stay high and An SHALL stay constant until ACKn is sampled high. On that edge VALIDn<=0 and the FSM goes to RELEASE.
REQ-021 In RELEASE, the FSM SHALL wait until not active, then go to IDLE, so one press produces exactly one VALID.
REQ-022 ACKn sampled while VALIDn is low SHALL be ignored.
REQ-023 En_L sampled high in any state SHALL force IDLE, CNT=0 and VALIDn<=0 on that edge. This has priority over ACKn and over the REQ-016 transition. An SHALL hold its last value.
REQ-024 An SHALL change only at the DEBOUNCE-to-PRESENT transition.
REQ-025 CNT SHALL be 4 bits and SHALL never wrap, because it is bounded by DB_CYCLES-1.

Reset
REQ-026 RST_L low SHALL immediately, without waiting for a clock edge, set:
- IREG=4'b1111, state IDLE, CAND=0, CNT=0, An=2'b00, VALIDn=0, GSn_L=1;
- this applies to both channels.
REQ-027 Reset asserted mid-operation, including while in PRESENT, SHALL discard any pending code; after RST_L rises, a still-held request SHALL be debounced again from scratch.

Verification
REQ-028 Bench SHALL cover: DB_CYCLES=4, E1_L=0, I1_L=4'b1110 held from before edge 0 -> GS1_L=0 after edge 0, VALID1=1 and A1=0 after edge 4; ACK1 pulsed -> VALID1=0 next edge; I1_L still held -> no second VALID1; I1_L released, then pressed again -> new VALID1.
REQ-029 Bench SHALL cover: I1_L=4'b0101 -> A1=3 (priority).
REQ-030 Bench SHALL cover: glitch, I1_L=4'b1011 for 2 cycles then 4'b1101 held -> debounce restarts; A1=1 exactly 4 edges after IREG captures 4'b1101; A1=2 is never presented.
REQ-031 Bench SHALL cover: E2_L raised while VALID2=1 -> VALID2=0 next edge, A2 unchanged, GS2_L=1; channel 1 traffic running at the same time is unaffected.
REQ-032 Bench SHALL cover: RST_L pulsed low between clock edges while in PRESENT -> VALID1=0, A1=0, GS1_L=1 immediately; after release with the request still held -> VALID1 returns 4 edges after IREG recaptures.
REQ-033 Bench SHALL cover: ACK1 held high continuously with no request, then a press -> VALID1 rises once at the expected edge and drops on the next edge.

Source files
------------

// File: rtl/dual_key_encoder_74x148.sv
// Dual-channel debounced 8-to-3 style key encoder (74x148-like priority
// encoding of four active-low request lines per channel). Each channel
// registers its request lines, debounces the priority code over DB_CYCLES
// consecutive matching samples, presents the code until acknowledged, and
// then waits for the key to be released before accepting another press.

module dual_key_encoder_channel #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_l,
    input  logic [3:0] req_l,
    input  logic       ack,
    output logic [1:0] code,
    output logic       valid,
    output logic       gs_l
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESENT  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Terminal count: the sample that completes a run of DB_CYCLES matches.
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    // Priority code: index of the highest-numbered low (active) request bit.
    function automatic logic [1:0] prio_code(input logic [3:0] lines_l);
        logic [1:0] result;
        if (lines_l[3] == 1'b0) begin
            result = 2'd3;
        end else if (lines_l[2] == 1'b0) begin
            result = 2'd2;
        end else if (lines_l[1] == 1'b0) begin
            result = 2'd1;
        end else begin
            result = 2'd0;
        end
        return result;
    endfunction

    state_t     state_r, state_s;
    logic [3:0] ireg_r;
    logic [1:0] cand_r, cand_s;
    logic [3:0] cnt_r, cnt_s;
    logic [1:0] a_r, a_s;
    logic       valid_r, valid_s;
    logic       gs_l_r, gs_l_s;
    logic       active_s;
    logic [1:0] cur_code_s;

    // Decode the registered request lines; every FSM decision uses these.
    always_comb begin
        active_s   = ~(&ireg_r);
        cur_code_s = prio_code(ireg_r);
    end

    // Next-state and output logic for the debounce / present / release FSM.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        valid_s = valid_r;
        // Group select tracks the request lines as they are captured.
        gs_l_s  = ~((~(&req_l)) & ~en_l);

        if (en_l) begin
            // Disabled channel drops any pending code but keeps the last A.
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
            valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (active_s) begin
                        cand_s  = cur_code_s;
                        cnt_s   = 4'd1;
                        state_s = ST_DEBOUNCE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!active_s) begin
                        state_s = ST_IDLE;
                        cnt_s   = 4'd0;
                    end else if (cur_code_s != cand_r) begin
                        // A different key won priority: restart the run.
                        cand_s = cur_code_s;
                        cnt_s  = 4'd1;
                    end else if (cnt_r == DB_LAST) begin
                        a_s     = cand_r;
                        valid_s = 1'b1;
                        cnt_s   = 4'd0;
                        state_s = ST_PRESENT;
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        valid_s = 1'b0;
                        state_s = ST_RELEASE;
                    end else begin
                        state_s = ST_PRESENT;
                    end
                end
                ST_RELEASE: begin
                    // One press yields one code: wait for the key to go up.
                    if (!active_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                    valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, input capture and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ireg_r  <= 4'b1111;
            state_r <= ST_IDLE;
            cand_r  <= 2'd0;
            cnt_r   <= 4'd0;
            a_r     <= 2'd0;
            valid_r <= 1'b0;
            gs_l_r  <= 1'b1;
        end else begin
            ireg_r  <= req_l;
            state_r <= state_s;
            cand_r  <= cand_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            valid_r <= valid_s;
            gs_l_r  <= gs_l_s;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        code  = a_r;
        valid = valid_r;
        gs_l  = gs_l_r;
    end

endmodule

module dual_key_encoder_74x148 #(
    parameter int DB_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_L,
    input  logic       E1_L,
    input  logic       E2_L,
    input  logic [3:0] I1_L,
    input  logic [3:0] I2_L,
    input  logic       ACK1,
    input  logic       ACK2,
    output logic [1:0] A1,
    output logic [1:0] A2,
    output logic       VALID1,
    output logic       VALID2,
    output logic       GS1_L,
    output logic       GS2_L
);

    dual_key_encoder_channel #(
        .DB_CYCLES (DB_CYCLES)
    ) u_ch1 (
        .clk   (CLK),
        .rst_n (RST_L),
        .en_l  (E1_L),
        .req_l (I1_L),
        .ack   (ACK1),
        .code  (A1),
        .valid (VALID1),
        .gs_l  (GS1_L)
    );

    dual_key_encoder_channel #(
        .DB_CYCLES (DB_CYCLES)
    ) u_ch2 (
        .clk   (CLK),
        .rst_n (RST_L),
        .en_l  (E2_L),
        .req_l (I2_L),
        .ack   (ACK2),
        .code  (A2),
        .valid (VALID2),
        .gs_l  (GS2_L)
    );

endmodule
